// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encoding,
// request owner codes and the latched bus request record.
package mem_arbiter_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_BREQ = 4'b0010,
    S_BRSP = 4'b0100,
    S_CRSP = 4'b1000
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    owner_t      owner;
  } bus_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Grant and bus-stall event counters for mem_arbiter; free-running, wrap at 2^32.
module mem_arb_perf
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_inst,
  input  logic             inc_data,
  input  logic             inc_stall,
  output logic [CNT_W-1:0] cnt_inst,
  output logic [CNT_W-1:0] cnt_data,
  output logic [CNT_W-1:0] cnt_stall
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_inst  <= '0;
      cnt_data  <= '0;
      cnt_stall <= '0;
    end else begin
      if (inc_inst)  cnt_inst  <= cnt_inst + 1'b1;
      if (inc_data)  cnt_data  <= cnt_data + 1'b1;
      if (inc_stall) cnt_stall <= cnt_stall + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch, load/store) arbiter onto a single-outstanding memory bus.
// Build option: define MEM_ARBITER_PERF_EN to include the performance counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  output logic        bus_rsp_ready,
  output logic [31:0] arb_perf_cnt_0,
  output logic [31:0] arb_perf_cnt_1,
  output logic [31:0] arb_perf_cnt_2
);

  state_t      state;
  bus_req_t    req;
  logic [31:0] rsp_buf;
  logic        data_req;
  logic        is_idle;
  logic        grant_d;
  logic        grant_i;

  assign data_req = MemRead | MemWrite;
  assign is_idle  = (state == S_IDLE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (DATA_PRIO) begin
      grant_d = 1'b1;
      grant_i = ~data_req;
    end else begin
      grant_i = 1'b1;
      grant_d = ~Inst_Req_Valid;
    end
  end

  assign Mem_Req_Ready  = is_idle & data_req & grant_d;
  assign Inst_Req_Ready = is_idle & Inst_Req_Valid & grant_i;

  // NOTE: state and registered outputs use <= so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      req             <= '0;
      // NOTE: the response buffer is a plain register, so it is reset like any other state.
      rsp_buf         <= '0;
      bus_req_valid   <= 1'b0;
      bus_rsp_ready   <= 1'b0;
      Inst_Valid      <= 1'b0;
      Read_data_Valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Mem_Req_Ready) begin
            // A simultaneous load+store is issued as the store.
            req <= '{addr: Address, wen: MemWrite,
                     wdata: MemWrite ? Write_data : '0,
                     wstrb: MemWrite ? Write_strb : '0, owner: OWN_DATA};
            bus_req_valid <= 1'b1;
            state         <= S_BREQ;
          end else if (Inst_Req_Ready) begin
            req <= '{addr: word_align(PC), wen: 1'b0, wdata: '0,
                     wstrb: '0, owner: OWN_INST};
            bus_req_valid <= 1'b1;
            state         <= S_BREQ;
          end
        end
        S_BREQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            if (req.wen) begin
              state <= S_IDLE;
            end else begin
              bus_rsp_ready <= 1'b1;
              state         <= S_BRSP;
            end
          end
        end
        S_BRSP: begin
          if (bus_rsp_valid) begin
            rsp_buf       <= bus_rsp_data;
            bus_rsp_ready <= 1'b0;
            state         <= S_CRSP;
            if (req.owner == OWN_INST) Inst_Valid      <= 1'b1;
            else                       Read_data_Valid <= 1'b1;
          end
        end
        S_CRSP: begin
          if ((Inst_Valid & Inst_Ready) | (Read_data_Valid & Read_data_Ready)) begin
            Inst_Valid      <= 1'b0;
            Read_data_Valid <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: begin
          bus_req_valid   <= 1'b0;
          bus_rsp_ready   <= 1'b0;
          Inst_Valid      <= 1'b0;
          Read_data_Valid <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_req_addr  = req.addr;
  assign bus_req_wen   = req.wen;
  assign bus_req_wdata = req.wdata;
  assign bus_req_wstrb = req.wstrb;
  assign Instruction   = rsp_buf;
  assign Read_data     = rsp_buf;

`ifdef MEM_ARBITER_PERF_EN
  mem_arb_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .inc_inst  (Inst_Req_Ready),
    .inc_data  (Mem_Req_Ready),
    .inc_stall (bus_req_valid & ~bus_req_ready),
    .cnt_inst  (arb_perf_cnt_0),
    .cnt_data  (arb_perf_cnt_1),
    .cnt_stall (arb_perf_cnt_2)
  );
`else
  assign arb_perf_cnt_0 = '0;
  assign arb_perf_cnt_1 = '0;
  assign arb_perf_cnt_2 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, stalled store, priority + held load,
// mid-transaction reset and load+store collision, with hand-computed expectations.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;
  logic        bus_rsp_ready;
  logic [31:0] arb_perf_cnt_0;
  logic [31:0] arb_perf_cnt_1;
  logic [31:0] arb_perf_cnt_2;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.DATA_PRIO(1'b1)) dut (
    .clk(clk), .rst(rst), .PC(PC),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .bus_rsp_ready(bus_rsp_ready),
    .arb_perf_cnt_0(arb_perf_cnt_0), .arb_perf_cnt_1(arb_perf_cnt_1),
    .arb_perf_cnt_2(arb_perf_cnt_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    PC = '0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b0;
    Address = '0; MemWrite = 1'b0; MemRead = 1'b0; Write_data = '0; Write_strb = '0;
    Read_data_Ready = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_breq_valid", bus_req_valid, 0);
    check("rst_breq_addr", bus_req_addr, 0);
    check("rst_rsp_ready", bus_rsp_ready, 0);
    check("rst_ivalid", Inst_Valid, 0);
    check("rst_rdvalid", Read_data_Valid, 0);
    check("rst_instr", Instruction, 0);
    check("rst_inst_ready", Inst_Req_Ready, 0);
    check("rst_cnt0", arb_perf_cnt_0, 0);
    check("rst_cnt2", arb_perf_cnt_2, 0);
    rst = 1'b0;

    // Fetch PC=0x104, response two cycles after the bus handshake
    tick(); PC = 32'h0000_0104; Inst_Req_Valid = 1'b1; settle();
    check("f_inst_ready", Inst_Req_Ready, 1);
    check("f_mem_ready", Mem_Req_Ready, 0);
    tick(); Inst_Req_Valid = 1'b0; bus_req_ready = 1'b1; settle();
    check("f_breq_valid", bus_req_valid, 1);
    check("f_breq_addr", bus_req_addr, 32'h104);
    check("f_breq_wen", bus_req_wen, 0);
    check("f_breq_wstrb", bus_req_wstrb, 0);
    tick(); bus_req_ready = 1'b0; settle();
    check("f_breq_drop", bus_req_valid, 0);
    check("f_rsp_ready", bus_rsp_ready, 1);
    check("f_ivalid_early", Inst_Valid, 0);
    tick(); bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0051_0513; settle();
    check("f_rsp_ready2", bus_rsp_ready, 1);
    tick(); bus_rsp_valid = 1'b0; bus_rsp_data = '0; settle();
    check("f_ivalid", Inst_Valid, 1);
    check("f_instr", Instruction, 32'h0051_0513);
    check("f_rsp_ready_off", bus_rsp_ready, 0);
    check("f_rdvalid", Read_data_Valid, 0);
    tick(); Inst_Ready = 1'b1; settle();
    check("f_ivalid_hold", Inst_Valid, 1);
    tick(); Inst_Ready = 1'b0; settle();
    check("f_ivalid_drop", Inst_Valid, 0);
    check("f_instr_hold", Instruction, 32'h0051_0513);
    check("f_cnt0", arb_perf_cnt_0, 32'(PERF));

    // Store 0xDEADBEEF to 0x80, bus stalls three cycles
    MemWrite = 1'b1; Address = 32'h80; Write_data = 32'hDEAD_BEEF; Write_strb = 4'hC; settle();
    check("s_mem_ready", Mem_Req_Ready, 1);
    tick(); MemWrite = 1'b0; Address = 32'hFFFF_FFF0; Write_data = '0; Write_strb = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      bus_req_ready = (i == 3);
      settle();
      check("s_valid", bus_req_valid, 1);
      check("s_addr", bus_req_addr, 32'h80);
      check("s_wen", bus_req_wen, 1);
      check("s_wdata", bus_req_wdata, 32'hDEAD_BEEF);
      check("s_wstrb", bus_req_wstrb, 4'hC);
    end
    tick(); bus_req_ready = 1'b0; settle();
    check("s_done_valid", bus_req_valid, 0);
    check("s_no_rsp", bus_rsp_ready, 0);
    check("s_cnt2", arb_perf_cnt_2, 32'(PERF * 3));
    check("s_cnt1", arb_perf_cnt_1, 32'(PERF));
    Inst_Req_Valid = 1'b1; settle();
    check("s_idle", Inst_Req_Ready, 1);
    Inst_Req_Valid = 1'b0;

    // Simultaneous load and fetch: data wins; load response held 6 cycles
    tick(); MemRead = 1'b1; Address = 32'h200; Inst_Req_Valid = 1'b1; PC = 32'h107; settle();
    check("p_mem_ready", Mem_Req_Ready, 1);
    check("p_inst_ready", Inst_Req_Ready, 0);
    tick(); MemRead = 1'b0; Address = '0; bus_req_ready = 1'b1; settle();
    check("p_valid", bus_req_valid, 1);
    check("p_addr", bus_req_addr, 32'h200);
    check("p_wen", bus_req_wen, 0);
    check("p_inst_blocked", Inst_Req_Ready, 0);
    tick(); bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 32'h1234_5678; settle();
    check("p_rsp_ready", bus_rsp_ready, 1);
    tick(); bus_rsp_data = 32'hFFFF_0000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      Read_data_Ready = (i == 5);
      settle();
      check("l_valid", Read_data_Valid, 1);
      check("l_data", Read_data, 32'h1234_5678);
      check("l_rsp_ready", bus_rsp_ready, 0);
      check("l_ivalid", Inst_Valid, 0);
      check("l_inst_blocked", Inst_Req_Ready, 0);
    end
    tick(); Read_data_Ready = 1'b0; bus_rsp_valid = 1'b0; settle();
    check("l_valid_drop", Read_data_Valid, 0);
    check("l_data_hold", Read_data, 32'h1234_5678);
    check("p_inst_ready2", Inst_Req_Ready, 1);
    check("p_cnt1", arb_perf_cnt_1, 32'(PERF * 2));
    tick(); Inst_Req_Valid = 1'b0; bus_req_ready = 1'b1; settle();
    check("p_faddr", bus_req_addr, 32'h104);
    check("p_fvalid", bus_req_valid, 1);
    tick(); bus_req_ready = 1'b0; settle();
    check("p_in_brsp", bus_rsp_ready, 1);
    check("p_cnt0", arb_perf_cnt_0, 32'(PERF * 2));

    // Reset while waiting for the fetch response, then a late response pulse
    rst = 1'b1; settle();
    check("r_rsp_ready", bus_rsp_ready, 0);
    check("r_instr", Instruction, 0);
    check("r_cnt0", arb_perf_cnt_0, 0);
    check("r_cnt1", arb_perf_cnt_1, 0);
    check("r_cnt2", arb_perf_cnt_2, 0);
    tick(); rst = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 32'hCAFE_F00D; settle();
    check("r_rsp_ready2", bus_rsp_ready, 0);
    tick(); settle();
    check("r_ivalid", Inst_Valid, 0);
    check("r_rdvalid", Read_data_Valid, 0);
    tick(); bus_rsp_valid = 1'b0; settle();
    check("r_ivalid2", Inst_Valid, 0);
    check("r_instr2", Instruction, 0);
    check("r_breq", bus_req_valid, 0);
    Inst_Req_Valid = 1'b1; settle();
    check("r_idle", Inst_Req_Ready, 1);
    Inst_Req_Valid = 1'b0;

    // MemRead and MemWrite together are issued as a posted write
    tick(); MemRead = 1'b1; MemWrite = 1'b1; Address = 32'h44;
    Write_data = 32'h1122_3344; Write_strb = 4'hF; settle();
    check("b_ready", Mem_Req_Ready, 1);
    tick(); MemRead = 1'b0; MemWrite = 1'b0; bus_req_ready = 1'b1; settle();
    check("b_wen", bus_req_wen, 1);
    check("b_addr", bus_req_addr, 32'h44);
    check("b_wdata", bus_req_wdata, 32'h1122_3344);
    tick(); bus_req_ready = 1'b0; settle();
    check("b_no_rsp", bus_rsp_ready, 0);
    check("b_valid_drop", bus_req_valid, 0);
    check("b_cnt1", arb_perf_cnt_1, 32'(PERF));

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: DATA_PRIO, 1, 1 = data channel wins simultaneous requests; 0 = instruction channel wins.
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  PC  in  32  instruction fetch address
  Inst_Req_Valid  in  1  fetch request
  Inst_Req_Ready  out  1  fetch request accepted
  Instruction  out  32  fetched word
  Inst_Valid  out  1  fetched word valid
  Inst_Ready  in  1  CPU takes fetched word
  Address  in  32  data address, word aligned
  MemWrite  in  1  store request
  MemRead  in  1  load request
  Write_data  in  32  store data
  Write_strb  in  4  store byte enables
  Mem_Req_Ready  out  1  load/store request accepted
  Read_data  out  32  load word
  Read_data_Valid  out  1  load word valid
  Read_data_Ready  in  1  CPU takes load word
  bus_req_valid  out  1  memory bus request
  bus_req_ready  in  1  bus accepts request
  bus_req_addr  out  32  bus address
  bus_req_wen  out  1  1 = write
  bus_req_wdata  out  32  write data
  bus_req_wstrb  out  4  write strobes
  bus_rsp_valid  in  1  read data valid
  bus_rsp_data  in  32  read data
  bus_rsp_ready  out  1  arbiter takes read data
  arb_perf_cnt_0  out  32  instruction grants
  arb_perf_cnt_1  out  32  data grants
  arb_perf_cnt_2  out  32  cycles with bus_req_valid=1 and bus_req_ready=0

Function
REQ-003 SHALL use a one-hot FSM with states IDLE, BREQ, BRSP, CRSP; exactly one transaction outstanding at a time.
REQ-004 IDLE: Mem_Req_Ready = (MemRead|MemWrite) & grant_d; Inst_Req_Ready = Inst_Req_Valid & grant_i; both combinational, never high together.
REQ-005 Grant: on a simultaneous request, the DATA_PRIO winner is granted; otherwise the sole requester is granted. The accepted request (addr, wen, wdata, wstrb, owner) SHALL be latched on that edge; go to BREQ.
REQ-006 For instruction requests, bus_req_addr SHALL be PC with bits [1:0] forced to 0; wen=0, wstrb=0.
REQ-007 BREQ: bus_req_valid=1; request fields SHALL be held stable until bus_req_ready. On handshake: write -> IDLE (posted, no response); read -> BRSP.
REQ-008 BRSP: bus_rsp_ready=1; on bus_rsp_valid, capture bus_rsp_data into the response buffer; go to CRSP.
REQ-009 CRSP: owner=instr -> Inst_Valid=1, Instruction=buffer; owner=data -> Read_data_Valid=1, Read_data=buffer; hold until the matching ready; then go to IDLE.
REQ-010 Minimum read latency: request accepted at edge N; bus_req_valid high in cycle N+1; with zero-wait bus, CPU valid high in cycle N+3.
REQ-011 bus_rsp_valid outside BRSP SHALL be ignored; MemRead and MemWrite both high SHALL be treated as write.
REQ-012 Instruction/Read_data SHALL hold the last captured word when not valid.
REQ-013 Counters SHALL be 32-bit, wrap modulo 2^32; cnt_0/cnt_1 increment on the grant edge, cnt_2 on each stalled BREQ cycle.

Reset
REQ-014 On rst (async): state=IDLE; all ready/valid outputs 0 except IDLE-derived readies; bus_req_* = 0; response buffer = 0; counters = 0.
REQ-015 A reset mid-transaction SHALL abandon it; a late bus_rsp_valid after reset SHALL be ignored.

Configuration
REQ-016 Macro MEM_ARBITER_PERF_EN: defined -> counters per REQ-013; undefined -> counter registers absent, arb_perf_cnt_0..2 tied to 0.

Structure
REQ-017 Shared package SHALL hold the state encoding constants and owner codes (OWN_INST, OWN_DATA).
REQ-018 One sub-module, mem_arb_perf, SHALL contain the counters; it is instantiated only under MEM_ARBITER_PERF_EN.

Verification
REQ-019 Fetch PC=0x0000_0104, bus returns 0x0051_0513 after 2 cycles -> bus_req_addr=0x104 wen=0; Instruction=0x0051_0513 with Inst_Valid until Inst_Ready.
REQ-020 Store Address=0x80, data 0xDEAD_BEEF, strb 0xC, bus_req_ready low for 3 cycles -> fields stable 4 cycles, cnt_2 += 3, no response wait, back to IDLE.
REQ-021 MemRead and Inst_Req_Valid same cycle, DATA_PRIO=1 -> Mem_Req_Ready=1, Inst_Req_Ready=0; fetch granted only after load completes.
REQ-022 Load response 0x1234_5678 with Read_data_Ready low 5 cycles -> Read_data_Valid held 6 cycles, data stable, bus_rsp_ready=0 throughout.
REQ-023 rst asserted in BRSP, then bus_rsp_valid pulses -> state IDLE, no Inst_Valid/Read_data_Valid, counters 0.
REQ-024 Build without MEM_ARBITER_PERF_EN, run REQ-019..021 -> identical handshakes, arb_perf_cnt_* constantly 0.
